// File: rtl/mem_arbiter.sv
// Purpose: two-port burst-locked arbiter sharing one memory master between I-cache (s0) and D-cache (s1); MEM_ARB_RR_EN selects round-robin ties (default: s1 wins ties).
// Latency: owner is registered, so the first forwarded beat appears one cycle after VALID rises in idle; forwarding itself is combinational.
// Backpressure: owner READY mirrors i_mem_READY; the non-owner sees READY=0 until the owner drops VALID (one dead cycle per handoff).
module mem_arbiter #(
    parameter int TOTAL_ADDR_W = 18,
    parameter int CNT_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [TOTAL_ADDR_W-1:0] i_s0_ADDR,
    input  logic [31:0]             i_s0_WDATA,
    input  logic [3:0]              i_s0_BMASK,
    input  logic                    i_s0_WREN,
    input  logic                    i_s0_VALID,
    output logic [31:0]             o_s0_RDATA,
    output logic                    o_s0_READY,
    input  logic [TOTAL_ADDR_W-1:0] i_s1_ADDR,
    input  logic [31:0]             i_s1_WDATA,
    input  logic [3:0]              i_s1_BMASK,
    input  logic                    i_s1_WREN,
    input  logic                    i_s1_VALID,
    output logic [31:0]             o_s1_RDATA,
    output logic                    o_s1_READY,
    output logic [TOTAL_ADDR_W-1:0] o_mem_ADDR,
    output logic [31:0]             o_mem_WDATA,
    output logic [3:0]              o_mem_BMASK,
    output logic                    o_mem_WREN,
    output logic                    o_mem_VALID,
    input  logic [31:0]             i_mem_RDATA,
    input  logic                    i_mem_READY,
    output logic [1:0]              o_GRANT,
    output logic [CNT_W-1:0]        o_s0_GCNT,
    output logic [CNT_W-1:0]        o_s1_GCNT
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    arb_state_t       state_q, state_d;
    logic             any_vld;
    logic             arb_fire;   // an arbitration decision is taken this cycle
    logic             win;        // 0: s0 wins, 1: s1 wins
    logic [CNT_W-1:0] gcnt0_q, gcnt1_q;

    assign any_vld = i_s0_VALID | i_s1_VALID;

`ifdef MEM_ARB_RR_EN
    logic last_q;

    // Round-robin pick: on a tie the port that did not win last time goes first
    always_comb begin
        if (i_s0_VALID && i_s1_VALID) win = ~last_q;
        else                          win = i_s1_VALID;
    end

    // Remember the most recent winner; reset value makes s0 win the first tie
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      last_q <= 1'b1;
        else if (arb_fire) last_q <= win;
    end
`else
    // Fixed priority: the D-cache port wins whenever it requests
    assign win = i_s1_VALID;
`endif

    // Owner state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    // Next owner and master-port forwarding; idle master drives all zeros
    always_comb begin
        state_d     = state_q;
        arb_fire    = 1'b0;
        o_mem_ADDR  = '0;
        o_mem_WDATA = '0;
        o_mem_BMASK = '0;
        o_mem_WREN  = 1'b0;
        o_mem_VALID = 1'b0;
        o_s0_READY  = 1'b0;
        o_s1_READY  = 1'b0;
        case (state_q)
            ARB_GNT0: begin
                if (i_s0_VALID) begin
                    o_mem_ADDR  = i_s0_ADDR;
                    o_mem_WDATA = i_s0_WDATA;
                    o_mem_BMASK = i_s0_BMASK;
                    o_mem_WREN  = i_s0_WREN;
                    o_mem_VALID = 1'b1;
                    o_s0_READY  = i_mem_READY;
                end else begin
                    arb_fire = any_vld;
                    state_d  = ARB_IDLE;
                end
            end
            ARB_GNT1: begin
                if (i_s1_VALID) begin
                    o_mem_ADDR  = i_s1_ADDR;
                    o_mem_WDATA = i_s1_WDATA;
                    o_mem_BMASK = i_s1_BMASK;
                    o_mem_WREN  = i_s1_WREN;
                    o_mem_VALID = 1'b1;
                    o_s1_READY  = i_mem_READY;
                end else begin
                    arb_fire = any_vld;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                arb_fire = any_vld;
            end
        endcase
        if (arb_fire) state_d = win ? ARB_GNT1 : ARB_GNT0;
    end

    // Saturating per-port grant counters, bumped on every new grant
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else if (arb_fire) begin
            if (!win && (gcnt0_q != {CNT_W{1'b1}})) gcnt0_q <= gcnt0_q + CNT_W'(1);
            if ( win && (gcnt1_q != {CNT_W{1'b1}})) gcnt1_q <= gcnt1_q + CNT_W'(1);
        end
    end

    assign o_GRANT    = {state_q == ARB_GNT1, state_q == ARB_GNT0};
    assign o_s0_RDATA = i_mem_RDATA;
    assign o_s1_RDATA = i_mem_RDATA;
    assign o_s0_GCNT  = gcnt0_q;
    assign o_s1_GCNT  = gcnt1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter (default build and MEM_ARB_RR_EN build).
// Latency: checks every cycle at the falling edge against a port-ownership model.
// Backpressure: directed memory stalls and cross-port contention exercise the READY gating.
module tb_mem_arbiter;

    localparam int AW = 18;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr_in  [2];
    logic [31:0]   wdata_in [2];
    logic [3:0]    bmask_in [2];
    logic          wren_in  [2];
    logic          vld_in   [2];
    logic [31:0]   mem_rdata;
    logic          mem_rdy;

    logic [31:0]   s0_rdata, s1_rdata, s0_rdata_b, s1_rdata_b;
    logic          s0_rdy, s1_rdy, s0_rdy_b, s1_rdy_b;
    logic [AW-1:0] m_addr, m_addr_b;
    logic [31:0]   m_wdata, m_wdata_b;
    logic [3:0]    m_bmask, m_bmask_b;
    logic          m_wren, m_wren_b, m_vld, m_vld_b;
    logic [1:0]    grant, grant_b;
    logic [15:0]   gcnt0, gcnt1;
    logic [1:0]    gcnt0_b, gcnt1_b;

    mem_arbiter #(.TOTAL_ADDR_W(AW), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s0_ADDR(addr_in[0]), .i_s0_WDATA(wdata_in[0]), .i_s0_BMASK(bmask_in[0]),
        .i_s0_WREN(wren_in[0]), .i_s0_VALID(vld_in[0]),
        .o_s0_RDATA(s0_rdata), .o_s0_READY(s0_rdy),
        .i_s1_ADDR(addr_in[1]), .i_s1_WDATA(wdata_in[1]), .i_s1_BMASK(bmask_in[1]),
        .i_s1_WREN(wren_in[1]), .i_s1_VALID(vld_in[1]),
        .o_s1_RDATA(s1_rdata), .o_s1_READY(s1_rdy),
        .o_mem_ADDR(m_addr), .o_mem_WDATA(m_wdata), .o_mem_BMASK(m_bmask),
        .o_mem_WREN(m_wren), .o_mem_VALID(m_vld),
        .i_mem_RDATA(mem_rdata), .i_mem_READY(mem_rdy),
        .o_GRANT(grant), .o_s0_GCNT(gcnt0), .o_s1_GCNT(gcnt1)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation
    mem_arbiter #(.TOTAL_ADDR_W(AW), .CNT_W(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s0_ADDR(addr_in[0]), .i_s0_WDATA(wdata_in[0]), .i_s0_BMASK(bmask_in[0]),
        .i_s0_WREN(wren_in[0]), .i_s0_VALID(vld_in[0]),
        .o_s0_RDATA(s0_rdata_b), .o_s0_READY(s0_rdy_b),
        .i_s1_ADDR(addr_in[1]), .i_s1_WDATA(wdata_in[1]), .i_s1_BMASK(bmask_in[1]),
        .i_s1_WREN(wren_in[1]), .i_s1_VALID(vld_in[1]),
        .o_s1_RDATA(s1_rdata_b), .o_s1_READY(s1_rdy_b),
        .o_mem_ADDR(m_addr_b), .o_mem_WDATA(m_wdata_b), .o_mem_BMASK(m_bmask_b),
        .o_mem_WREN(m_wren_b), .o_mem_VALID(m_vld_b),
        .i_mem_RDATA(mem_rdata), .i_mem_READY(mem_rdy),
        .o_GRANT(grant_b), .o_s0_GCNT(gcnt0_b), .o_s1_GCNT(gcnt1_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: who owns the master (0 none, 1 = s0, 2 = s1), last winner, grant tallies
    int own_m  = 0;
    int last_m = 1;
    int cnt_m [2] = '{0, 0};
    int cyc    = 0;

    // Observations for the literal checks
    logic [AW-1:0] got0[$], got1[$];
    int            gotc0[$], gotc1[$];
    logic [1:0]    gseq[$];
    logic [1:0]    prev_g = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Spec-level winner choice for the requests currently pending
    function automatic int pick();
        if (vld_in[0] && vld_in[1]) begin
`ifdef MEM_ARB_RR_EN
            return (last_m == 0) ? 1 : 0;
`else
            return 1;
`endif
        end
        return vld_in[1] ? 1 : 0;
    endfunction

    // Compare DUT outputs to the ownership model, then advance the model
    task automatic model_step();
        int          p;
        logic        act;
        logic [1:0]  eg;
        int          w;
        p   = (own_m == 0) ? 0 : own_m - 1;
        act = (own_m != 0) && vld_in[p];
        eg  = (own_m == 0) ? 2'b00 : ((own_m == 1) ? 2'b01 : 2'b10);
        chk("mem_valid", m_vld,   act);
        chk("mem_wren",  m_wren,  act ? wren_in[p]  : 1'b0);
        chk("mem_addr",  m_addr,  act ? addr_in[p]  : '0);
        chk("mem_wdata", m_wdata, act ? wdata_in[p] : '0);
        chk("mem_bmask", m_bmask, act ? bmask_in[p] : '0);
        chk("s0_ready",  s0_rdy,  act && own_m == 1 && mem_rdy);
        chk("s1_ready",  s1_rdy,  act && own_m == 2 && mem_rdy);
        chk("s0_rdata",  s0_rdata, mem_rdata);
        chk("s1_rdata",  s1_rdata, mem_rdata);
        chk("grant",     grant,   eg);
        chk("gcnt0",     gcnt0,   sat(cnt_m[0], 65535));
        chk("gcnt1",     gcnt1,   sat(cnt_m[1], 65535));
        chk("grant_b",   grant_b, eg);
        chk("mem_vld_b", m_vld_b, act);
        chk("gcnt0_b",   gcnt0_b, sat(cnt_m[0], 3));
        chk("gcnt1_b",   gcnt1_b, sat(cnt_m[1], 3));
        if (act && mem_rdy) begin
            if (p == 0) begin got0.push_back(addr_in[0]); gotc0.push_back(cyc); end
            else        begin got1.push_back(addr_in[1]); gotc1.push_back(cyc); end
        end
        if (grant != 2'b00 && grant != prev_g) gseq.push_back(grant);
        prev_g = grant;
        if (!rst_n) begin
            own_m  = 0;
            last_m = 1;
            cnt_m  = '{0, 0};
        end else if (!act) begin
            if (vld_in[0] || vld_in[1]) begin
                w = pick();
                own_m = w + 1;
                cnt_m[w]++;
                last_m = w;
            end else begin
                own_m = 0;
            end
        end
        cyc++;
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // Memory read data changes every cycle so RDATA forwarding is visible
    initial begin
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdata = $urandom;
        end
    end

    // Drive an n-beat burst on port p; each beat holds until its READY is seen
    task automatic burst(input int p, input logic [AW-1:0] base, input int n, input int nwr, input int dly);
        bit hs;
        int k;
        repeat (dly) tick();
        for (int i = 0; i < n; i++) begin
            addr_in[p]  = base + AW'(4 * i);
            wdata_in[p] = 32'hD000_0000 | 32'(base) | 32'(i << 20);
            bmask_in[p] = (i % 2 == 1) ? 4'h3 : 4'hF;
            wren_in[p]  = (i < nwr);
            vld_in[p]   = 1'b1;
            hs = 1'b0;
            k  = 0;
            while (!hs && k < 100) begin
                @(negedge clk);
                hs = (p == 0) ? s0_rdy : s1_rdy;
                tick();
                k++;
            end
            if (!hs) begin
                n_chk++;
                n_fail++;
                $display("FAIL burst_timeout: port %0d beat %0d got no READY in 100 cycles, expected a handshake", p, i);
                break;
            end
        end
        vld_in[p]   = 1'b0;
        wren_in[p]  = 1'b0;
        addr_in[p]  = '0;
        wdata_in[p] = '0;
        bmask_in[p] = '0;
    endtask

    // Completed beats on port p must be exactly base, base+4, ... once each
    task automatic check_seq(input string nm, input int p, input logic [AW-1:0] base, input int n);
        logic [AW-1:0] q[$];
        q = (p == 0) ? got0 : got1;
        chk({nm, "_beats"}, q.size(), n);
        for (int i = 0; i < q.size() && i < n; i++)
            chk({nm, "_addr"}, q[i], base + AW'(4 * i));
    endtask

    task automatic clear_obs();
        got0.delete(); got1.delete(); gotc0.delete(); gotc1.delete(); gseq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    int sat_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        rst_n   = 1'b0;
        mem_rdy = 1'b1;
        for (int p = 0; p < 2; p++) begin
            addr_in[p] = '0; wdata_in[p] = '0; bmask_in[p] = '0;
            wren_in[p] = 1'b0; vld_in[p] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_mem_valid", m_vld, 1'b0);
        chk("rst_gcnt0", gcnt0, 16'd0);
        chk("rst_gcnt1", gcnt1, 16'd0);
        tick();

        // Single 16-beat request on s0
        clear_obs();
        fork
            burst(0, 18'h00100, 16, 0, 0);
            begin
                @(negedge clk);
                chk("t1_pre_grant", grant, 2'b00);
                @(negedge clk);
                chk("t1_grant", grant, 2'b01);
                chk("t1_first_beat", m_vld, 1'b1);
            end
        join
        tick();
        check_seq("t1", 0, 18'h00100, 16);
        chk("t1_back_to_back", gotc0[15] - gotc0[0], 15);
        chk("t1_gcnt0", gcnt0, 16'd1);

        // s1 write-back + fetch lock; s0 arrives mid-burst
        do_reset();
        clear_obs();
        fork
            burst(1, 18'h02000, 32, 16, 0);
            burst(0, 18'h03000, 4, 0, 5);
        join
        tick();
        check_seq("t2_s1", 1, 18'h02000, 32);
        check_seq("t2_s0", 0, 18'h03000, 4);
        chk("t2_handoff_gap", gotc0[0] - gotc1[31], 2);
        chk("t2_grants", gseq.size(), 2);
        chk("t2_first_owner", gseq[0], 2'b10);

        // Tie straight out of idle
        do_reset();
        clear_obs();
        fork
            burst(0, 18'h00400, 2, 0, 0);
            burst(1, 18'h00500, 2, 2, 0);
        join
        tick();
        chk("t3_grants", gseq.size(), 2);
`ifdef MEM_ARB_RR_EN
        chk("t3_tie_first", gseq[0], 2'b01);
        chk("t3_tie_second", gseq[1], 2'b10);
`else
        chk("t3_tie_first", gseq[0], 2'b10);
        chk("t3_tie_second", gseq[1], 2'b01);
`endif

        // Memory stall of three cycles in the middle of an s1 burst
        do_reset();
        clear_obs();
        fork
            burst(1, 18'h00800, 8, 8, 0);
            begin
                repeat (4) tick();
                mem_rdy = 1'b0;
                repeat (3) tick();
                mem_rdy = 1'b1;
            end
        join
        tick();
        check_seq("t4", 1, 18'h00800, 8);
        chk("t4_span", gotc1[7] - gotc1[0], 10);

        // Reset in the middle of an s1 burst, s0 waiting afterwards
        do_reset();
        vld_in[1] = 1'b1; addr_in[1] = 18'h00C00; wren_in[1] = 1'b1;
        wdata_in[1] = 32'h1234_5678; bmask_in[1] = 4'hF;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vld_in[1] = 1'b0; wren_in[1] = 1'b0;
        vld_in[0] = 1'b1; addr_in[0] = 18'h00040;
        @(negedge clk);
        chk("t5_mem_valid", m_vld, 1'b0);
        chk("t5_grant", grant, 2'b00);
        chk("t5_gcnt1", gcnt1, 16'd0);
        chk("t5_s1_ready", s1_rdy, 1'b0);
        tick();
        @(negedge clk);
        chk("t5_s0_regrant", grant, 2'b01);
        tick();
        vld_in[0] = 1'b0; addr_in[0] = '0;
        tick();

        // Grant counter saturation on the two-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            burst(0, 18'h00600 + AW'(i * 16), 1, 0, 0);
            @(negedge clk);
            chk("t6_gcnt0_sat", gcnt0_b, sat_exp[i]);
            chk("t6_gcnt0_wide", gcnt0, i + 1);
            tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
